// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data memory between the CPU
// load/store path and the host/loader port. One memory strobe per granted
// transaction, one-cycle acknowledge, registered per-requester read data.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          init,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  input  logic          host_lock,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          memory_r_en,
  output logic          memory_w_en,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant;
  logic   grant_host;
  logic   lat_we;

  // Arbitration and next-state decode; requests only matter in IDLE
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_host = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || host_req) begin
          grant = 1'b1;
          if (cpu_req && host_req) begin
            // A locked host that already owns the port keeps it;
            // otherwise the tie goes to whoever did not win last time.
            if (owner && host_lock) grant_host = 1'b1;
            else                    grant_host = ~owner;
          end else begin
            grant_host = host_req;
          end
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = lat_we ? ACK : CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, grant latch and per-requester read-data capture
  always_ff @(posedge clk) begin
    if (init) begin
      state      <= IDLE;
      owner      <= 1'b1;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_in     <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= grant_host;
        if (grant_host) begin
          lat_we   <= host_we;
          mem_addr <= host_addr;
          mem_in   <= host_wdata;
        end else begin
          lat_we   <= cpu_we;
          mem_addr <= cpu_addr;
          mem_in   <= cpu_wdata;
        end
      end
      if (state == CAPTURE) begin
        if (owner) host_rdata <= mem_out;
        else       cpu_rdata  <= mem_out;
      end
    end
  end

  // Strobes, acks and busy are decoded from registered state only
  assign memory_w_en = (state == ACCESS) &&  lat_we;
  assign memory_r_en = (state == ACCESS) && !lat_we;
  assign cpu_ack     = (state == ACK) && !owner;
  assign host_ack    = (state == ACK) &&  owner;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized two-port run,
// checked against a transaction-level memory image and arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          init = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic          memory_r_en, memory_w_en;
  logic [DW-1:0] mem_out = '0;
  logic          busy, owner;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .init(init),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_lock(host_lock),
    .mem_addr(mem_addr), .mem_in(mem_in), .memory_r_en(memory_r_en),
    .memory_w_en(memory_w_en), .mem_out(mem_out), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port memory the arbiter drives
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (memory_w_en) mem[mem_addr] <= mem_in;
    if (memory_r_en) mem_out <= mem[mem_addr];
  end

  // Reference memory image, updated once per completed transaction
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  // Strobe observer: counts strobes, overlaps and who owned each strobe
  int strobe_cnt = 0;
  int overlap_cnt = 0;
  int strobe_owner [$];
  always @(negedge clk) begin
    if (memory_r_en || memory_w_en) begin
      strobe_cnt++;
      strobe_owner.push_back(int'(owner));
    end
    if (memory_r_en && memory_w_en) overlap_cnt++;
  end

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  // Stimulus only: issue one transaction from an IDLE cycle, return cycles to ack (-1 on timeout)
  task automatic run_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int lat);
    if (port) begin
      host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port && host_ack) || (!port && cpu_ack)) begin
        lat = i;
        break;
      end
    end
    if (port) host_req = 1'b0;
    else      cpu_req = 1'b0;
    if (lat > 0 && we) ref_mem[addr] = wdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat;
    int acks;
    init = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpu_ack !== 1'b0 || host_ack !== 1'b0 || memory_r_en !== 1'b0 ||
        memory_w_en !== 1'b0 || cpu_rdata !== 8'h00 || host_rdata !== 8'h00 ||
        mem_addr !== 8'h00 || mem_in !== 8'h00 || owner !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: busy=%b acks=%b%b strobes=%b%b rdata=%h/%h addr=%h din=%h owner=%b, required all 0 with owner=1",
               busy, cpu_ack, host_ack, memory_r_en, memory_w_en, cpu_rdata, host_rdata, mem_addr, mem_in, owner);
    end
    init = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 8'h33, 8'h00, lat);
    checks++;
    if (lat !== 3 || cpu_rdata !== ref_mem[8'h33] || owner !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_read: lat=%0d rdata=%h owner=%b, required 3 %h 0", lat, cpu_rdata, ref_mem[8'h33], owner);
    end
    // Start a read, then reset while it is in ACCESS
    cpu_we = 1'b0; cpu_addr = 8'h34; cpu_req = 1'b1;
    @(negedge clk);
    checks++;
    if (memory_r_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_access: memory_r_en=%b, required 1", memory_r_en);
    end
    init = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (memory_r_en !== 1'b0 || memory_w_en !== 1'b0 || cpu_ack !== 1'b0 || host_ack !== 1'b0 ||
        busy !== 1'b0 || cpu_rdata !== 8'h00 || owner !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read: strobes=%b%b acks=%b%b busy=%b cpu_rdata=%h owner=%b, required 0 0 0 0 0 00 1",
               memory_r_en, memory_w_en, cpu_ack, host_ack, busy, cpu_rdata, owner);
    end
    @(negedge clk);
    init = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL aborted_no_ack: cpu_ack pulses=%0d, required 0", acks);
    end
  endtask

  task automatic test_host_write_cpu_read();
    logic [DW-1:0] hr_before;
    int lat;
    hr_before = host_rdata;
    host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A; host_req = 1'b1;
    @(negedge clk);
    checks++;
    if (memory_w_en !== 1'b1 || memory_r_en !== 1'b0 || mem_addr !== 8'h10 || mem_in !== 8'h5A) begin
      errors++;
      $display("FAIL host_write_strobe: w_en=%b r_en=%b addr=%h din=%h, required 1 0 10 5a",
               memory_w_en, memory_r_en, mem_addr, mem_in);
    end
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b1 || memory_w_en !== 1'b0) begin
      errors++;
      $display("FAIL host_write_ack: host_ack=%b w_en=%b, required 1 0", host_ack, memory_w_en);
    end
    host_req = 1'b0;
    ref_mem[8'h10] = 8'h5A;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_cycle: host_ack=%b busy=%b, required 0 0", host_ack, busy);
    end
    run_txn(1'b0, 1'b0, 8'h10, 8'h00, lat);
    checks++;
    if (lat !== 3 || cpu_rdata !== 8'h5A || host_rdata !== hr_before) begin
      errors++;
      $display("FAIL cpu_read_back: lat=%0d cpu_rdata=%h host_rdata=%h, required 3 5a %h", lat, cpu_rdata, host_rdata, hr_before);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    bit c_done, h_done, first;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    #1;
    base = strobe_cnt;
    strobe_owner.delete();
    c_done = 1'b0; h_done = 1'b0; first = 1'b1;
    cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h99; cpu_req = 1'b1;
    host_we = 1'b0; host_addr = 8'h41; host_req = 1'b1;
    for (int i = 0; i < 20 && !(c_done && h_done); i++) begin
      @(negedge clk);
      if (first) begin
        first = 1'b0;
        checks++;
        if (owner !== 1'b0) begin
          errors++;
          $display("FAIL tie_first_owner: owner=%b, required 0", owner);
        end
      end
      if (cpu_ack) begin cpu_req = 1'b0; c_done = 1'b1; ref_mem[8'h40] = 8'h99; end
      if (host_ack) begin host_req = 1'b0; h_done = 1'b1; end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!(c_done && h_done) || strobe_cnt - base !== 2 || strobe_owner.size() != 2 ||
        strobe_owner[0] !== 0 || strobe_owner[1] !== 1 || overlap_cnt !== 0) begin
      errors++;
      $display("FAIL tie_order: done=%b%b strobes=%0d overlaps=%0d, required 11 2 0 with owners C then H",
               c_done, h_done, strobe_cnt - base, overlap_cnt);
    end
    checks++;
    if (host_rdata !== ref_mem[8'h41]) begin
      errors++;
      $display("FAIL tie_host_read: host_rdata=%h, required %h", host_rdata, ref_mem[8'h41]);
    end
  endtask

  task automatic test_contention();
    int order [$];
    int cc, hc;
    cc = 0; hc = 0;
    host_lock = 1'b0;
    cpu_we = 1'b0; cpu_addr = 8'h60; cpu_req = 1'b1;
    host_we = 1'b1; host_addr = 8'h61; host_wdata = 8'($urandom); host_req = 1'b1;
    for (int i = 0; i < 80 && (cpu_req || host_req); i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        order.push_back(0); cc++;
        if (cc == 3) cpu_req = 1'b0;
        else cpu_addr = cpu_addr + 8'h1;
      end
      if (host_ack) begin
        order.push_back(1); hc++;
        ref_mem[host_addr] = host_wdata;
        if (hc == 3) host_req = 1'b0;
        else begin host_addr = host_addr + 8'h2; host_wdata = 8'($urandom); end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    checks++;
    if (order.size() != 6) begin
      errors++;
      $display("FAIL contention_count: grants=%0d, required 6", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] !== i % 2) begin
        errors++;
        $display("FAIL contention_order[%0d]: got %0d, required %0d (0=CPU 1=host)", i, order[i], i % 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_host_lock();
    int hc;
    bit c_done;
    logic [DW-1:0] d;
    hc = 0; c_done = 1'b0;
    host_lock = 1'b1;
    d = 8'($urandom);
    host_we = 1'b1; host_addr = 8'h50; host_wdata = d; host_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 8'h50; cpu_req = 1'b1;
    for (int i = 0; i < 60 && (cpu_req || host_req); i++) begin
      @(negedge clk);
      if (host_ack) begin
        ref_mem[host_addr] = host_wdata;
        hc++;
        if (hc == 3) host_lock = 1'b0;
        if (hc == 4) host_req = 1'b0;
        else begin host_addr = host_addr + 8'h1; host_wdata = 8'($urandom); end
      end
      if (cpu_ack) begin
        c_done = 1'b1;
        cpu_req = 1'b0;
        checks++;
        if (hc !== 3 || cpu_rdata !== ref_mem[8'h50]) begin
          errors++;
          $display("FAIL host_lock_order: host acks before cpu_ack=%0d cpu_rdata=%h, required 3 %h", hc, cpu_rdata, ref_mem[8'h50]);
        end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    checks++;
    if (!c_done || hc !== 4) begin
      errors++;
      $display("FAIL host_lock_done: cpu_done=%b host_acks=%0d, required 1 4", c_done, hc);
    end
    @(negedge clk);
  endtask

  task automatic test_data_isolation();
    int l1, l2, l3, l4;
    run_txn(1'b1, 1'b1, 8'h20, 8'h11, l1);
    run_txn(1'b1, 1'b1, 8'h21, 8'h22, l2);
    run_txn(1'b0, 1'b0, 8'h20, 8'h00, l3);
    checks++;
    if (l1 !== 2 || l2 !== 2 || l3 !== 3 || cpu_rdata !== 8'h11) begin
      errors++;
      $display("FAIL iso_cpu_read: lat=%0d/%0d/%0d cpu_rdata=%h, required 2/2/3 11", l1, l2, l3, cpu_rdata);
    end
    run_txn(1'b1, 1'b0, 8'h21, 8'h00, l4);
    repeat (2) @(negedge clk);
    checks++;
    if (l4 !== 3 || host_rdata !== 8'h22 || cpu_rdata !== 8'h11 || mem_addr !== 8'h21) begin
      errors++;
      $display("FAIL iso_host_read: lat=%0d host_rdata=%h cpu_rdata=%h mem_addr=%h, required 3 22 11 21",
               l4, host_rdata, cpu_rdata, mem_addr);
    end
  endtask

  task automatic test_random();
    txn_t cq [$];
    txn_t hq [$];
    txn_t t;
    int cyc, prev_cyc, exp_who, who;
    bit done;
    logic [DW-1:0] rd;
    cyc = 0; prev_cyc = -1; done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t.we = 1'($urandom_range(0, 1)); t.addr = 8'h80 + 8'($urandom_range(0, 7)); t.data = 8'($urandom);
      cq.push_back(t);
      t.we = 1'($urandom_range(0, 1)); t.addr = 8'h80 + 8'($urandom_range(0, 7)); t.data = 8'($urandom);
      hq.push_back(t);
    end
    host_lock = 1'b0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    exp_who = 0;
    cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].data; cpu_req = 1'b1;
    host_we = hq[0].we; host_addr = hq[0].addr; host_wdata = hq[0].data; host_req = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack || host_ack) begin
        who = host_ack ? 1 : 0;
        checks++;
        if (who !== exp_who || (cpu_ack && host_ack)) begin
          errors++;
          $display("FAIL rand_grant: acks=%b%b, required ack from %0d (0=CPU 1=host)", cpu_ack, host_ack, exp_who);
        end
        t = who ? hq[0] : cq[0];
        if (t.we) ref_mem[t.addr] = t.data;
        else begin
          rd = who ? host_rdata : cpu_rdata;
          checks++;
          if (rd !== ref_mem[t.addr]) begin
            errors++;
            $display("FAIL rand_rdata: port=%0d addr=%h got %h, required %h", who, t.addr, rd, ref_mem[t.addr]);
          end
        end
        if (prev_cyc >= 0) begin
          checks++;
          if (cyc - prev_cyc !== (t.we ? 3 : 4)) begin
            errors++;
            $display("FAIL rand_interval: we=%b got %0d cycles, required %0d", t.we, cyc - prev_cyc, t.we ? 3 : 4);
          end
        end
        prev_cyc = cyc;
        if (who == 1) begin
          void'(hq.pop_front());
          if (hq.size() > 0) begin host_we = hq[0].we; host_addr = hq[0].addr; host_wdata = hq[0].data; end
          else host_req = 1'b0;
        end else begin
          void'(cq.pop_front());
          if (cq.size() > 0) begin cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].data; end
          else cpu_req = 1'b0;
        end
        if (cq.size() > 0 && hq.size() > 0) exp_who = (who == 1) ? 0 : 1;
        else exp_who = (hq.size() > 0) ? 1 : 0;
        done = (cq.size() == 0 && hq.size() == 0);
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rand_timeout: pending cpu=%0d host=%0d, required 0 0", cq.size(), hq.size());
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h33] = 8'h77;
    ref_mem[8'h33] = 8'h77;
    test_reset();
    test_host_write_cpu_read();
    test_simultaneous();
    test_contention();
    test_host_lock();
    test_data_isolation();
    test_random();
    #1;
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: cycles with both strobes=%0d, required 0", overlap_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
